flash_bus_arbiter: RTL and testbench

Shares the single configuration-flash pin set between two masters: requester 0 is the QSPI controller and requester 1 is the SPI master. It grants exclusive ownership with a req/gnt handshake, registers the pad-side mux, and enforces a CS-high guard gap between owners. A watchdog revokes a grant when an idle owner starves the other requester. It replaces ad-hoc combinational pin muxing at the top level.

---
 rtl/flash_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_flash_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_bus_arbiter.sv
// Arbiter for the shared configuration-flash pins: QSPI controller (req 0)
// versus SPI master (req 1). It grants ownership through a req/gnt handshake,
// registers the pad mux, and inserts a CS-high guard gap between owners.
// A watchdog revokes the grant from an idle owner that starves the other side.
module flash_bus_arbiter #(
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter int unsigned TO_W         = 16
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic [1:0] iREQ,
  output logic [1:0] oGNT,
  output logic [1:0] oREVOKED,
  input  logic       iQ_SCK,
  input  logic       iQ_CSn,
  input  logic [3:0] iQ_DOUT,
  input  logic [3:0] iQ_DOE,
  input  logic       iS_SCK,
  input  logic       iS_CSn,
  input  logic       iS_MOSI,
  output logic       oFL_SCK,
  output logic       oFL_CSn,
  output logic [3:0] oFL_DOUT,
  output logic [3:0] oFL_DOE,
  output logic       oBUSY
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_e;

  localparam logic [7:0]      GAP_LOAD = 8'(GAP_CYCLES - 1);
  localparam bit              WD_EN    = (IDLE_TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST  = WD_EN ? TO_W'(IDLE_TIMEOUT - 1) : '0;

  // Pads park with CSn high, HOLD/WP driven high and MISO/MOSI released.
  localparam logic [3:0] PAD_DOUT_RST = 4'b1100;
  localparam logic [3:0] PAD_DOE_RST  = 4'b1100;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      rev_q, rev_d;
  logic            last_q, last_d;
  logic [7:0]      gap_q, gap_d;
  logic [TO_W-1:0] wd_q, wd_d;

  logic            sck_q, sck_d;
  logic            csn_q, csn_d;
  logic [3:0]      dout_q, dout_d;
  logic [3:0]      doe_q, doe_d;

  logic            own_idx;
  logic            own_csn;
  logic            own_req;
  logic            oth_req;

  // Owner-relative view of the request and chip-select lines.
  always_comb begin
    own_idx = (state_q == OWN1);
    own_csn = own_idx ? iS_CSn : iQ_CSn;
    own_req = iREQ[own_idx];
    oth_req = iREQ[~own_idx];
  end

  // Next-state, grant, guard-gap and watchdog decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rev_d   = '0;
    last_d  = last_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        // Round robin on a tie: the requester that did not own last wins.
        if (iREQ == 2'b01 || (iREQ == 2'b11 && last_q)) begin
          state_d = OWN0;
          gnt_d   = 2'b01;
        end else if (iREQ[1]) begin
          state_d = OWN1;
          gnt_d   = 2'b10;
        end
      end
      OWN0, OWN1: begin
        // Release only with CSn high so a frame in flight is never cut.
        if (!own_req && own_csn) begin
          state_d = GAP;
          gnt_d   = '0;
          last_d  = own_idx;
          gap_d   = GAP_LOAD;
          wd_d    = '0;
        end else if (WD_EN && own_csn && oth_req) begin
          if (wd_q == WD_LAST) begin
            state_d        = GAP;
            gnt_d          = '0;
            rev_d[own_idx] = 1'b1;
            last_d         = own_idx;
            gap_d          = GAP_LOAD;
            wd_d           = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end else begin
          wd_d = '0;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad mux selected by the current owner; everything else parks the pads.
  always_comb begin
    sck_d  = 1'b0;
    csn_d  = 1'b1;
    dout_d = PAD_DOUT_RST;
    doe_d  = PAD_DOE_RST;
    case (state_q)
      OWN0: begin
        sck_d  = iQ_SCK;
        csn_d  = iQ_CSn;
        dout_d = iQ_DOUT;
        doe_d  = iQ_DOE;
      end
      OWN1: begin
        sck_d  = iS_SCK;
        csn_d  = iS_CSn;
        dout_d = {3'b110, iS_MOSI};
        doe_d  = 4'b1101;
      end
      default: ;
    endcase
  end

  // Control state registers.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rev_q   <= '0;
      last_q  <= 1'b1;
      gap_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rev_q   <= rev_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
    end
  end

  // Single pad register stage; async reset parks the pads immediately.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      sck_q  <= 1'b0;
      csn_q  <= 1'b1;
      dout_q <= PAD_DOUT_RST;
      doe_q  <= PAD_DOE_RST;
    end else begin
      sck_q  <= sck_d;
      csn_q  <= csn_d;
      dout_q <= dout_d;
      doe_q  <= doe_d;
    end
  end

  assign oGNT     = gnt_q;
  assign oREVOKED = rev_q;
  assign oFL_SCK  = sck_q;
  assign oFL_CSn  = csn_q;
  assign oFL_DOUT = dout_q;
  assign oFL_DOE  = doe_q;
  assign oBUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Bench for flash_bus_arbiter: one instance with an 8-cycle watchdog and one
// with the watchdog disabled, both driven by the same stimulus and compared
// every cycle against an ownership-level reference model.
module tb_flash_bus_arbiter;

  localparam int unsigned GAP = 4;
  localparam int unsigned TO  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       qsck, qcsn, ssck, scsn, smosi;
  logic [3:0] qdout, qdoe;

  logic [1:0] gnt   [2];
  logic [1:0] rev   [2];
  logic       fsck  [2];
  logic       fcsn  [2];
  logic [3:0] fdout [2];
  logic [3:0] fdoe  [2];
  logic       busy  [2];

  always #5 clk = ~clk;

  flash_bus_arbiter #(.GAP_CYCLES(GAP), .IDLE_TIMEOUT(TO), .TO_W(16)) dut (
    .iCLK(clk), .iRESETn(rst_n), .iREQ(req), .oGNT(gnt[0]), .oREVOKED(rev[0]),
    .iQ_SCK(qsck), .iQ_CSn(qcsn), .iQ_DOUT(qdout), .iQ_DOE(qdoe),
    .iS_SCK(ssck), .iS_CSn(scsn), .iS_MOSI(smosi),
    .oFL_SCK(fsck[0]), .oFL_CSn(fcsn[0]), .oFL_DOUT(fdout[0]), .oFL_DOE(fdoe[0]),
    .oBUSY(busy[0])
  );

  flash_bus_arbiter #(.GAP_CYCLES(GAP), .IDLE_TIMEOUT(0), .TO_W(16)) dut_nw (
    .iCLK(clk), .iRESETn(rst_n), .iREQ(req), .oGNT(gnt[1]), .oREVOKED(rev[1]),
    .iQ_SCK(qsck), .iQ_CSn(qcsn), .iQ_DOUT(qdout), .iQ_DOE(qdoe),
    .iS_SCK(ssck), .iS_CSn(scsn), .iS_MOSI(smosi),
    .oFL_SCK(fsck[1]), .oFL_CSn(fcsn[1]), .oFL_DOUT(fdout[1]), .oFL_DOE(fdoe[1]),
    .oBUSY(busy[1])
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model: owner (-1 none), guard cycles left, last owner, idle run.
  int         m_to   [2];
  int         m_own  [2];
  int         m_gap  [2];
  int         m_last [2];
  int         m_run  [2];
  logic [1:0] x_gnt  [2];
  logic [1:0] x_rev  [2];
  logic       x_sck  [2];
  logic       x_csn  [2];
  logic       x_busy [2];
  logic [3:0] x_dout [2];
  logic [3:0] x_doe  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_to[0] = TO;
    m_to[1] = 0;
    for (int m = 0; m < 2; m++) begin
      m_own[m]  = -1;
      m_gap[m]  = 0;
      m_last[m] = 1;
      m_run[m]  = 0;
      x_gnt[m]  = 2'b00;
      x_rev[m]  = 2'b00;
      x_sck[m]  = 1'b0;
      x_csn[m]  = 1'b1;
      x_dout[m] = 4'b1100;
      x_doe[m]  = 4'b1100;
      x_busy[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    int   o;
    logic cs;
    for (int m = 0; m < 2; m++) begin
      o = m_own[m];
      if (o == 0) begin
        x_sck[m] = qsck; x_csn[m] = qcsn; x_dout[m] = qdout; x_doe[m] = qdoe;
      end else if (o == 1) begin
        x_sck[m] = ssck; x_csn[m] = scsn; x_dout[m] = {3'b110, smosi}; x_doe[m] = 4'b1101;
      end else begin
        x_sck[m] = 1'b0; x_csn[m] = 1'b1; x_dout[m] = 4'b1100; x_doe[m] = 4'b1100;
      end
      x_rev[m] = 2'b00;
      if (m_gap[m] > 0) begin
        m_gap[m]--;
      end else if (o < 0) begin
        if (req == 2'b11)      m_own[m] = 1 - m_last[m];
        else if (req == 2'b10) m_own[m] = 1;
        else if (req == 2'b01) m_own[m] = 0;
        m_run[m] = 0;
      end else begin
        cs = (o == 1) ? scsn : qcsn;
        if (!req[o] && cs) begin
          m_own[m] = -1; m_gap[m] = GAP; m_last[m] = o;
        end else if (m_to[m] > 0 && cs && req[1-o]) begin
          m_run[m]++;
          if (m_run[m] == m_to[m]) begin
            x_rev[m][o] = 1'b1;
            m_own[m] = -1; m_gap[m] = GAP; m_last[m] = o; m_run[m] = 0;
          end
        end else begin
          m_run[m] = 0;
        end
      end
      x_gnt[m]  = (m_own[m] < 0) ? 2'b00 : ((m_own[m] == 0) ? 2'b01 : 2'b10);
      x_busy[m] = (m_own[m] >= 0) || (m_gap[m] > 0);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d_gnt", m),  gnt[m],   x_gnt[m]);
      chk($sformatf("d%0d_rev", m),  rev[m],   x_rev[m]);
      chk($sformatf("d%0d_sck", m),  fsck[m],  x_sck[m]);
      chk($sformatf("d%0d_csn", m),  fcsn[m],  x_csn[m]);
      chk($sformatf("d%0d_dout", m), fdout[m], x_dout[m]);
      chk($sformatf("d%0d_doe", m),  fdoe[m],  x_doe[m]);
      chk($sformatf("d%0d_busy", m), busy[m],  x_busy[m]);
    end
  endtask

  task automatic rnd_data();
    qsck  = 1'($urandom);
    qdout = 4'($urandom);
    qdoe  = 4'($urandom);
    ssck  = 1'($urandom);
    smosi = 1'($urandom);
  endtask

  // One clock: model advances on the edge, outputs are checked 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    rnd_data();
  endtask

  task automatic wait_gnt(input logic [1:0] g, input int budget, input string tag);
    int n = 0;
    while (gnt[0] !== g && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, gnt[0], g);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    req   = 2'b11;
    qcsn  = 1'b1;
    scsn  = 1'b1;
    rnd_data();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release with both requesting: QSPI wins the first tie.
    cycle();
    chk("rst_csn_e1", fcsn[0], 1'b1);
    cycle();
    chk("rst_gnt", gnt[0], 2'b01);
    chk("rst_csn_e2", fcsn[0], 1'b1);
    qcsn = 1'b0;
    cycle();
    chk("rst_mirror_csn", fcsn[0], 1'b0);
    repeat (3) cycle();

    // Round robin: QSPI releases while SPI waits.
    qcsn = 1'b1;
    req  = 2'b10;
    repeat (5) begin
      cycle();
      chk("rr_gap", gnt[0], 2'b00);
    end
    cycle();
    chk("rr_gnt1", gnt[0], 2'b10);
    scsn = 1'b0;
    cycle();
    chk("rr_doe", fdoe[0], 4'b1101);
    chk("rr_dout_hi", fdout[0][3:2], 2'b11);
    chk("rr_csn", fcsn[0], 1'b0);

    // Release request mid-frame: grant is held until CSn rises.
    req = 2'b00;
    repeat (10) begin
      cycle();
      chk("frame_hold", gnt[0], 2'b10);
    end
    scsn = 1'b1;
    cycle();
    chk("frame_gap", gnt[0], 2'b00);
    chk("frame_busy", busy[0], 1'b1);

    // Watchdog revokes an idle QSPI owner on the 8th qualifying cycle.
    req = 2'b01;
    wait_gnt(2'b01, 20, "wd_wait_q");
    req = 2'b11;
    repeat (7) begin
      cycle();
      chk("wd_norev", rev[0], 2'b00);
    end
    cycle();
    chk("wd_rev", rev[0], 2'b01);
    chk("wd_revgnt", gnt[0], 2'b00);
    chk("nw_keep", gnt[1], 2'b01);
    repeat (4) begin
      cycle();
      chk("wd_gap", gnt[0], 2'b00);
    end
    cycle();
    chk("wd_next", gnt[0], 2'b10);

    // A CSn-low pulse at count 5 restarts the idle count: no revoke.
    req = 2'b01;
    wait_gnt(2'b01, 20, "wd_wait_q2");
    req = 2'b11;
    repeat (5) begin
      cycle();
      chk("wd_cnt5", rev[0], 2'b00);
    end
    qcsn = 1'b0;
    cycle();
    chk("wd_clr", rev[0], 2'b00);
    qcsn = 1'b1;
    repeat (6) begin
      cycle();
      chk("wd_after", rev[0], 2'b00);
    end
    chk("wd_keep", gnt[0], 2'b01);

    // Watchdog disabled: an idle owner keeps the bus indefinitely.
    repeat (5000) begin
      cycle();
      chk("nw_gnt", gnt[1], 2'b01);
      chk("nw_rev", rev[1], 2'b00);
    end

    // Random traffic; only the owner's CSn may matter to the arbiter.
    repeat (2000) begin
      if ($urandom_range(7, 0) == 0) req = 2'($urandom);
      if ($urandom_range(3, 0) == 0) qcsn = ~qcsn;
      if ($urandom_range(3, 0) == 0) scsn = ~scsn;
      cycle();
    end

    // Async reset in the middle of a QSPI frame.
    req  = 2'b01;
    qcsn = 1'b0;
    scsn = 1'b1;
    n = 0;
    while (!(fcsn[0] === 1'b0 && fcsn[1] === 1'b0) && n < 60) begin
      cycle();
      n++;
    end
    chk("arst_wait", fcsn[0], 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("arst_csn", fcsn[m], 1'b1);
      chk("arst_gnt", gnt[m], 2'b00);
      chk("arst_doe", fdoe[m], 4'b1100);
      chk("arst_dout", fdout[m], 4'b1100);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle();
    chk("arst_regrant", gnt[0], 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
